// File: rtl/memory_stage.sv
// memory_stage: MEM stage of the five-stage MIPS pipeline.
// Performs loads/stores against an internal word-addressed RAM with WAIT_STATES
// extra cycles per access, stalls upstream while an access is in flight, and
// drives the MEM/WB pipeline register.
// Optional feature macro: MEM_ALIGN_CHECK_EN (suppress misaligned accesses and
// flag them on alignErrorOutput; when undefined the flag is tied 0).
//
// state  | meaning
// -------+-----------------------------------------------------------------
// S_IDLE | accepting a new EX/MEM instruction; non-memory ops commit at once
// S_WAIT | memory op latched, counting down wait states; commits at cnt==0
module memory_stage #(
    parameter int MEM_DEPTH_WORDS = 256,
    parameter int WAIT_STATES     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memToRegInput,
    input  logic        regWriteInput,
    input  logic        memWriteInput,
    input  logic        memReadInput,
    input  logic [31:0] aluResultInput,
    input  logic [31:0] memWriteDataInput,
    input  logic [4:0]  regWriteRegisterInput,
    output logic        stallOutput,
    output logic        memToRegOutput,
    output logic        regWriteOutput,
    output logic [31:0] memReadDataOutput,
    output logic [31:0] aluResultOutput,
    output logic [4:0]  regWriteRegisterOutput,
    output logic        alignErrorOutput
);

    localparam int         AW          = $clog2(MEM_DEPTH_WORDS);
    localparam logic [3:0] LP_CNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_cnt;
    logic [3:0]  w_cnt_nxt;
    logic        w_commit;
    logic        w_stall;
    logic        w_latch;

    // Copy of the EX/MEM contents taken when a waited access starts.
    logic        r_lat_mem_to_reg;
    logic        r_lat_reg_write;
    logic        r_lat_mem_write;
    logic        r_lat_mem_read;
    logic [31:0] r_lat_alu;
    logic [31:0] r_lat_wdata;
    logic [4:0]  r_lat_rd_reg;

    logic        r_mw_mem_to_reg;
    logic        r_mw_reg_write;
    logic [31:0] r_mw_rdata;
    logic [31:0] r_mw_alu;
    logic [4:0]  r_mw_rd_reg;
    logic        r_mw_align_err;

    logic [31:0] r_mem [MEM_DEPTH_WORDS];

    logic          w_in_mem_op;
    logic          w_sel_mem_to_reg;
    logic          w_sel_reg_write;
    logic          w_sel_mem_write;
    logic          w_sel_mem_read;
    logic [31:0]   w_sel_alu;
    logic [31:0]   w_sel_wdata;
    logic [4:0]    w_sel_rd_reg;
    logic [AW-1:0] w_word_idx;
    logic [31:0]   w_ram_word;
    logic          w_misalign;
    logic [31:0]   w_rdata;

    assign w_in_mem_op = memReadInput | memWriteInput;

    // In WAIT the commit uses the latched copy; in IDLE it uses the live inputs.
    assign w_sel_mem_to_reg = (r_state == S_WAIT) ? r_lat_mem_to_reg : memToRegInput;
    assign w_sel_reg_write  = (r_state == S_WAIT) ? r_lat_reg_write  : regWriteInput;
    assign w_sel_mem_write  = (r_state == S_WAIT) ? r_lat_mem_write  : memWriteInput;
    assign w_sel_mem_read   = (r_state == S_WAIT) ? r_lat_mem_read   : memReadInput;
    assign w_sel_alu        = (r_state == S_WAIT) ? r_lat_alu        : aluResultInput;
    assign w_sel_wdata      = (r_state == S_WAIT) ? r_lat_wdata      : memWriteDataInput;
    assign w_sel_rd_reg     = (r_state == S_WAIT) ? r_lat_rd_reg     : regWriteRegisterInput;

    // Upper address bits are dropped, so addresses wrap modulo the RAM size.
    assign w_word_idx = w_sel_alu[AW+1:2];
    assign w_ram_word = r_mem[w_word_idx];

`ifdef MEM_ALIGN_CHECK_EN
    assign w_misalign = (w_sel_mem_read | w_sel_mem_write) & (w_sel_alu[1:0] != 2'b00);
`else
    assign w_misalign = 1'b0;
`endif

    // Read-before-write: the word is sampled before any store on the same edge.
    assign w_rdata = (w_sel_mem_read && !w_misalign) ? w_ram_word : 32'd0;

    assign stallOutput = w_stall & ~reset;

    // Next-state, counter and commit/stall decode.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_commit    = 1'b0;
        w_stall     = 1'b0;
        w_latch     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_in_mem_op && (WAIT_STATES > 0)) begin
                    w_stall     = 1'b1;
                    w_latch     = 1'b1;
                    w_state_nxt = S_WAIT;
                    w_cnt_nxt   = LP_CNT_INIT;
                end else begin
                    w_commit = 1'b1;
                end
            end
            S_WAIT: begin
                if (r_cnt != 4'd0) begin
                    w_stall   = 1'b1;
                    w_cnt_nxt = r_cnt - 4'd1;
                end else begin
                    w_commit    = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = 4'd0;
            end
        endcase
    end

    // State and wait counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Capture the EX/MEM contents when a waited access begins.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_lat_mem_to_reg <= 1'b0;
            r_lat_reg_write  <= 1'b0;
            r_lat_mem_write  <= 1'b0;
            r_lat_mem_read   <= 1'b0;
            r_lat_alu        <= 32'd0;
            r_lat_wdata      <= 32'd0;
            r_lat_rd_reg     <= 5'd0;
        end else if (w_latch) begin
            r_lat_mem_to_reg <= memToRegInput;
            r_lat_reg_write  <= regWriteInput;
            r_lat_mem_write  <= memWriteInput;
            r_lat_mem_read   <= memReadInput;
            r_lat_alu        <= aluResultInput;
            r_lat_wdata      <= memWriteDataInput;
            r_lat_rd_reg     <= regWriteRegisterInput;
        end
    end

    // Data RAM write port; contents survive reset, a store cut off by reset is dropped.
    always_ff @(posedge clk) begin
        if (!reset && w_commit && w_sel_mem_write && !w_misalign) begin
            r_mem[w_word_idx] <= w_sel_wdata;
        end
    end

    // MEM/WB register: committed result, otherwise a bubble.
    always_ff @(posedge clk) begin
        if (reset || !w_commit) begin
            r_mw_mem_to_reg <= 1'b0;
            r_mw_reg_write  <= 1'b0;
            r_mw_rdata      <= 32'd0;
            r_mw_alu        <= 32'd0;
            r_mw_rd_reg     <= 5'd0;
            r_mw_align_err  <= 1'b0;
        end else begin
            r_mw_mem_to_reg <= w_sel_mem_to_reg;
            r_mw_reg_write  <= w_sel_reg_write & ~w_misalign;
            r_mw_rdata      <= w_rdata;
            r_mw_alu        <= w_sel_alu;
            r_mw_rd_reg     <= w_sel_rd_reg;
            r_mw_align_err  <= w_misalign;
        end
    end

    assign memToRegOutput         = r_mw_mem_to_reg;
    assign regWriteOutput         = r_mw_reg_write;
    assign memReadDataOutput      = r_mw_rdata;
    assign aluResultOutput        = r_mw_alu;
    assign regWriteRegisterOutput = r_mw_rd_reg;
    assign alignErrorOutput       = r_mw_align_err;

endmodule

// File: doc/memory_stage.md
# memory_stage

MEM stage of the five-stage MIPS pipeline. It consumes the EX/MEM pipeline register contents (the control bits, ALU result, store data and destination register produced by the executing stage) and performs loads and stores against an internal word-addressed data RAM with a configurable number of wait states. While an access is in flight it stalls everything upstream. It drives the MEM/WB pipeline register consumed by the write-back stage and by the executing stage's WB forwarding input.

## Interface
Parameters:
- MEM_DEPTH_WORDS, 256: RAM depth in 32-bit words; power of two, minimum 4.
- WAIT_STATES, 2: extra cycles per load/store, range 0..15.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high.
- memToRegInput, regWriteInput, memWriteInput, memReadInput  input  1 each  EX/MEM control bits.
- aluResultInput  input  32  byte address for memory ops; pass-through value otherwise.
- memWriteDataInput  input  32  store data, already forwarded.
- regWriteRegisterInput  input  5  destination register.
- stallOutput  output  1  combinational; while high, PC, IF/ID, ID/EX and EX/MEM hold.
- memToRegOutput, regWriteOutput  output  1 each  MEM/WB control bits.
- memReadDataOutput  output  32  MEM/WB load data.
- aluResultOutput  output  32  MEM/WB ALU result.
- regWriteRegisterOutput  output  5  MEM/WB destination register.
- alignErrorOutput  output  1  MEM/WB misaligned-access flag.

## Operation
- Memory op = memReadInput | memWriteInput. Word index = aluResultInput[log2(MEM_DEPTH_WORDS)+1:2]. Upper bits are ignored, so addresses wrap modulo the RAM size.
- States: IDLE, WAIT. The counter cnt is 4 bits wide.
- IDLE, non-memory op: no stall. MEM/WB loads the inputs with memReadDataOutput=0.
- IDLE, memory op, WAIT_STATES=0: commit on this edge with no stall.
- IDLE, memory op, WAIT_STATES>0: stallOutput=1. On the edge, latch all inputs, set cnt=WAIT_STATES-1 and go to WAIT. MEM/WB loads a bubble: all control bits 0, data fields 0.
- WAIT: stallOutput = (cnt!=0).
  - If cnt!=0: decrement cnt and load a bubble into MEM/WB.
  - If cnt==0: commit using the latched copy, then return to IDLE.
- Commit:
  - A store writes the RAM word.
  - A load places the RAM word in memReadDataOutput.
  - MEM/WB loads the control bits, aluResult and regWriteRegister.
- Both memRead and memWrite set: the store is performed, and memReadDataOutput returns the pre-write word (read-before-write).
- RAM contents are not cleared by reset.

## Timing
- Reset (any state, including mid-WAIT) forces IDLE, cnt=0 and all MEM/WB outputs to 0. A pending store is discarded (the RAM is not written). stallOutput is 0 during reset.
- A memory op first seen at cycle T holds stallOutput high for cycles T..T+WAIT_STATES-1. It commits at the end of cycle T+WAIT_STATES, and MEM/WB is valid in cycle T+WAIT_STATES+1.
- A non-memory op shows MEM/WB valid in cycle T+1.
- Upstream must hold the inputs stable while stallOutput is high. The block uses its latched copy regardless.
- Back-to-back memory ops each pay the full WAIT_STATES. There is no idle cycle between them.
- The edge that commits a store and the next instruction's load to the same word: the load, seen in IDLE at the next cycle, returns the new data.

## Configuration
- Macro: MEM_ALIGN_CHECK_EN.
- Defined: a memory op with aluResultInput[1:0]!=0 still goes through the full wait sequence, but the access is suppressed:
  - no RAM write;
  - memReadDataOutput=0;
  - regWriteOutput=0;
  - alignErrorOutput=1 for exactly the one MEM/WB cycle of that op.
- Undefined: address bits [1:0] are ignored, alignErrorOutput is tied 0, and the port remains present.

## Test plan
All scenarios use WAIT_STATES=2.
- Store 32'hDEADBEEF to addr 0x10, then load addr 0x10 -> stallOutput high 2 cycles per op, and memReadDataOutput=32'hDEADBEEF in the cycle after the load commits.
- ALU op, aluResult=0x1234, regWriteRegister=5 -> no stall, and the next cycle shows aluResultOutput=0x1234, regWriteOutput=1, regWriteRegisterOutput=5.
- Store to addr 0x400 with MEM_DEPTH_WORDS=256 -> a subsequent load of addr 0x0 returns the stored value (wrap).
- Reset asserted in the second stall cycle of a store of 0x55 to addr 0x8 -> all outputs 0 and state IDLE next cycle; a later load of 0x8 returns the old contents.
- Both memRead and memWrite set with old word 0x1, new word 0x2 -> memReadDataOutput=0x1, and the RAM holds 0x2.
- With MEM_ALIGN_CHECK_EN: load from addr 0x13 with regWrite=1 -> alignErrorOutput=1 and regWriteOutput=0 for one cycle, and memReadDataOutput=0.
